// File: rtl/wb_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master_pkg
// Purpose  : Shared types and constants for the Wishbone command master:
//            FSM state encoding, response record, bus data/select widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_cmd_master_pkg;

   localparam int c_wb_data_width = 32;
   localparam int c_wb_sel_width  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic [c_wb_data_width-1:0] dat;
      logic                       err;
      logic                       tmo;
   } rsp_t;

endpackage : wb_cmd_master_pkg
`default_nettype wire

// File: rtl/wb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master_if
// Purpose  : Bundles the command stream, response stream and Wishbone
//            master signals of wb_cmd_master.
// Modports : master - view of wb_cmd_master itself
//            slave  - view of the surrounding logic (command source,
//                     response sink and Wishbone slave)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_cmd_master_if #(
   parameter int g_addr_width = 14
);
   import wb_cmd_master_pkg::*;

   // command stream
   logic                       cmd_valid_i;
   logic                       cmd_ready_o;
   logic                       cmd_we_i;
   logic [g_addr_width-1:0]    cmd_adr_i;
   logic [c_wb_sel_width-1:0]  cmd_sel_i;
   logic [c_wb_data_width-1:0] cmd_dat_i;
   // response stream
   logic                       rsp_valid_o;
   logic                       rsp_ready_i;
   logic [c_wb_data_width-1:0] rsp_dat_o;
   logic                       rsp_err_o;
   logic                       rsp_tmo_o;
   // Wishbone pipelined master
   logic                       wb_cyc_o;
   logic                       wb_stb_o;
   logic                       wb_we_o;
   logic [g_addr_width-1:0]    wb_adr_o;
   logic [c_wb_sel_width-1:0]  wb_sel_o;
   logic [c_wb_data_width-1:0] wb_dat_o;
   logic                       wb_ack_i;
   logic                       wb_err_i;
   logic                       wb_rty_i;
   logic                       wb_stall_i;
   logic [c_wb_data_width-1:0] wb_dat_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
      output cmd_ready_o,
      input  rsp_ready_i,
      output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
      input  cmd_ready_o,
      output rsp_ready_i,
      input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
   );

endinterface : wb_cmd_master_if
`default_nettype wire

// File: rtl/wb_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_timeout
// Purpose  : Loadable down-counter for the bus timeout. Load sets the count
//            to g_timeout-1; each enabled cycle decrements it; expired_o is
//            high once the count reaches zero.
// Ports    : clk_i     - clock
//            rst_n_i   - synchronous active-low reset
//            load_i    - reload the counter (wins over en_i)
//            en_i      - count this cycle
//            expired_o - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_timeout #(
   parameter int g_timeout = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int                     c_cnt_width = $clog2(g_timeout + 1);
   localparam logic [c_cnt_width-1:0] c_load_val  = c_cnt_width'(g_timeout - 1);

   logic [c_cnt_width-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_cnt <= c_load_val;
      end else if (load_i) begin
         r_cnt <= c_load_val;
      end else if (en_i && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired_o = (r_cnt == '0);

endmodule : wb_cmd_timeout
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Single-outstanding Wishbone pipelined master. Converts a
//            valid/ready command stream into bus cycles and returns read
//            data/status on a valid/ready response stream. Retries on RTY
//            up to g_max_retry times and gives up after g_timeout cycles.
// Ports    : clk_i   - clock
//            rst_n_i - synchronous active-low reset
//            bus     - command, response and Wishbone signals (master view)
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int g_addr_width = 14,
   parameter int g_timeout    = 255,
   parameter int g_max_retry  = 3
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   wb_cmd_master_if.master  bus
);

   localparam int                     c_rty_width = (g_max_retry > 0) ? $clog2(g_max_retry + 1) : 1;
   localparam logic [c_rty_width-1:0] c_max_rty   = c_rty_width'(g_max_retry);

   state_t                     r_state, w_state_nxt;
   // r_gap marks the single cyc=0 cycle between a RTY and the reissued strobe
   logic                       r_gap, w_gap_nxt;
   logic                       r_cyc, r_stb, r_cmd_ready, r_rsp_valid;
   rsp_t                       r_rsp, w_rsp_nxt;
   logic [c_rty_width-1:0]     r_rty_cnt, w_rty_nxt;
   logic                       r_we;
   logic [g_addr_width-1:0]    r_adr;
   logic [c_wb_sel_width-1:0]  r_sel;
   logic [c_wb_data_width-1:0] r_dat;
   logic                       w_accept, w_tmr_load, w_tmr_en, w_expired;

   wb_cmd_timeout #(.g_timeout(g_timeout)) u_timeout (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .load_i    (w_tmr_load),
      .en_i      (w_tmr_en),
      .expired_o (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = 1'b0;
      w_rsp_nxt   = r_rsp;
      w_rty_nxt   = r_rty_cnt;
      w_accept    = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid_i && r_cmd_ready) begin
               w_accept    = 1'b1;
               w_rty_nxt   = '0;
               w_tmr_load  = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ, ST_WAIT: begin
            // Terminations are only honoured while cyc is high; in the retry
            // gap the state simply falls through to a fresh strobe.
            if (!r_gap) begin
               w_tmr_en = 1'b1;
               if (bus.wb_err_i) begin
                  w_rsp_nxt.dat = '0;
                  w_rsp_nxt.err = 1'b1;
                  w_rsp_nxt.tmo = 1'b0;
                  w_state_nxt   = ST_RESP;
               end else if (bus.wb_rty_i) begin
                  if (r_rty_cnt < c_max_rty) begin
                     w_rty_nxt   = r_rty_cnt + 1'b1;
                     w_tmr_load  = 1'b1;
                     w_gap_nxt   = 1'b1;
                     w_state_nxt = ST_REQ;
                  end else begin
                     w_rsp_nxt.dat = '0;
                     w_rsp_nxt.err = 1'b1;
                     w_rsp_nxt.tmo = 1'b0;
                     w_state_nxt   = ST_RESP;
                  end
               end else if (bus.wb_ack_i) begin
                  w_rsp_nxt.dat = r_we ? '0 : bus.wb_dat_i;
                  w_rsp_nxt.err = 1'b0;
                  w_rsp_nxt.tmo = 1'b0;
                  w_state_nxt   = ST_RESP;
               end else if (w_expired) begin
                  w_rsp_nxt.dat = '0;
                  w_rsp_nxt.err = 1'b0;
                  w_rsp_nxt.tmo = 1'b1;
                  w_state_nxt   = ST_RESP;
               end else if ((r_state == ST_REQ) && !bus.wb_stall_i) begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_gap       <= 1'b0;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
         r_rty_cnt   <= '0;
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_sel       <= '0;
         r_dat       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gap       <= w_gap_nxt;
         // Bus/handshake outputs are registered from the next state so they
         // change exactly on state entry.
         r_cyc       <= ((w_state_nxt == ST_REQ) && !w_gap_nxt) || (w_state_nxt == ST_WAIT);
         r_stb       <= (w_state_nxt == ST_REQ) && !w_gap_nxt;
         r_cmd_ready <= (w_state_nxt == ST_IDLE);
         r_rsp_valid <= (w_state_nxt == ST_RESP);
         r_rsp       <= w_rsp_nxt;
         r_rty_cnt   <= w_rty_nxt;
         if (w_accept) begin
            r_we  <= bus.cmd_we_i;
            r_adr <= bus.cmd_adr_i;
            r_sel <= bus.cmd_sel_i;
            r_dat <= bus.cmd_dat_i;
         end
      end
   end

   assign bus.cmd_ready_o = r_cmd_ready;
   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_dat_o   = r_rsp.dat;
   assign bus.rsp_err_o   = r_rsp.err;
   assign bus.rsp_tmo_o   = r_rsp.tmo;
   assign bus.wb_cyc_o    = r_cyc;
   assign bus.wb_stb_o    = r_stb;
   assign bus.wb_we_o     = r_we;
   assign bus.wb_adr_o    = r_adr;
   assign bus.wb_sel_o    = r_sel;
   assign bus.wb_dat_o    = r_dat;

endmodule : wb_cmd_master
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Self-checking bench for wb_cmd_master. A scripted Wishbone
//            slave answers each strobe; a transaction-level model predicts
//            strobe start cycles, response cycle and response contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;
   import wb_cmd_master_pkg::*;

   localparam int c_aw      = 14;
   localparam int c_tmo     = 16;
   localparam int c_max_rty = 3;
   localparam int c_budget  = 200;
   localparam int k_ack = 0, k_err = 1, k_rty = 2, k_none = 3, k_errack = 4, k_rtyack = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   wb_cmd_master_if #(.g_addr_width(c_aw)) bus ();

   wb_cmd_master #(
      .g_addr_width (c_aw),
      .g_timeout    (c_tmo),
      .g_max_retry  (c_max_rty)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];
   int          sc_kind [8];
   int          sc_dly  [8];
   logic        sc_stall[8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic slave_idle();
      bus.wb_ack_i   = 1'b0;
      bus.wb_err_i   = 1'b0;
      bus.wb_rty_i   = 1'b0;
      bus.wb_stall_i = 1'b0;
      bus.wb_dat_i   = $urandom;
   endtask

   task automatic set_step(input int i, input int kind, input int dly, input logic stall);
      sc_kind[i]  = kind;
      sc_dly[i]   = dly;
      sc_stall[i] = stall;
   endtask

   task automatic gen_script();
      int nr, r;
      nr = $urandom_range(0, 4);
      for (int i = 0; i < nr; i++)
         set_step(i, ($urandom_range(0, 1) != 0) ? k_rty : k_rtyack,
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      if (nr < 4) begin
         r = $urandom_range(0, 9);
         if (r <= 5)      set_step(nr, k_ack, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
         else if (r == 6) set_step(nr, k_err, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
         else if (r == 7) set_step(nr, k_errack, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
         else if (r == 8) set_step(nr, k_none, 1000, 1'($urandom_range(0, 1)));
         else             set_step(nr, k_ack, $urandom_range(10, 20), 1'($urandom_range(0, 1)));
      end
   endtask

   // One command: reference prediction, drive, act as slave, check response.
   task automatic run_txn(input logic we, input logic [c_aw-1:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int rst_at, input int hold_in);
      int          exp_s[8];
      int          n_str, exp_cyc, s, c, idx, age, s_start, k, hold;
      logic [31:0] exp_dat;
      logic        exp_err, exp_tmo, done, prev_stb;

      // Transaction-level prediction: each strobe either ends the command
      // or (RTY within budget) restarts 2 cycles after its termination.
      s = 1; n_str = 0; exp_cyc = 0; exp_dat = '0; exp_err = 1'b0; exp_tmo = 1'b0; done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         exp_s[i] = s;
         n_str    = i + 1;
         if (sc_kind[i] == k_none || sc_dly[i] > c_tmo - 1) begin
            exp_tmo = 1'b1; exp_cyc = s + c_tmo; done = 1'b1;
         end else if (sc_kind[i] == k_err || sc_kind[i] == k_errack) begin
            exp_err = 1'b1; exp_cyc = s + sc_dly[i] + 1; done = 1'b1;
         end else if (sc_kind[i] == k_rty || sc_kind[i] == k_rtyack) begin
            if (i < c_max_rty) s = s + sc_dly[i] + 2;
            else begin exp_err = 1'b1; exp_cyc = s + sc_dly[i] + 1; done = 1'b1; end
         end else begin
            exp_cyc = s + sc_dly[i] + 1; done = 1'b1;
            if (!we) exp_dat = ref_mem[adr[3:0]];
            else if (rst_at < 0)
               for (int b = 0; b < 4; b++)
                  if (sel[b]) ref_mem[adr[3:0]][8*b +: 8] = dat[8*b +: 8];
         end
      end

      @(negedge clk);
      check("cmd_ready_idle", bus.cmd_ready_o, 1'b1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_sel_i   = sel;
      bus.cmd_dat_i   = dat;
      @(posedge clk);
      c = 1; idx = -1; prev_stb = 1'b0; s_start = 0;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_dat_i   = $urandom;
      check("cmd_ready_busy", bus.cmd_ready_o, 1'b0);

      while (c < c_budget && !bus.rsp_valid_o) begin
         if (c == rst_at) begin
            check("pre_rst_wait", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
            rst_n = 1'b0;
            slave_idle();
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_cyc_stb", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b00);
            check("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
            check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check("rst_no_rsp", bus.rsp_valid_o, 1'b0);
            return;
         end
         slave_idle();
         if (bus.wb_stb_o && !prev_stb) begin
            idx++;
            s_start = c;
            if (idx < n_str) check("strobe_cycle", c, exp_s[idx]);
            else             check("strobe_count", idx + 1, n_str);
            check("wb_fields", {bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o},
                               {we, adr, sel, dat});
         end
         prev_stb = bus.wb_stb_o;
         if (bus.wb_cyc_o && idx >= 0 && idx < 8) begin
            age = c - s_start;
            // A stalled strobe must stay up; an unstalled one lasts one cycle.
            if (age > 0 && age <= sc_dly[idx]) check("stb_phase", bus.wb_stb_o, sc_stall[idx]);
            bus.wb_stall_i = sc_stall[idx] && (age < sc_dly[idx]);
            if (age == sc_dly[idx]) begin
               k = sc_kind[idx];
               bus.wb_ack_i = (k == k_ack || k == k_errack || k == k_rtyack);
               bus.wb_err_i = (k == k_err || k == k_errack);
               bus.wb_rty_i = (k == k_rty || k == k_rtyack);
               bus.wb_dat_i = slv_mem[bus.wb_adr_o[3:0]];
               if (k == k_ack && bus.wb_we_o)
                  for (int b = 0; b < 4; b++)
                     if (bus.wb_sel_o[b]) slv_mem[bus.wb_adr_o[3:0]][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
            end
         end
         @(posedge clk);
         c++;
         @(negedge clk);
      end

      slave_idle();
      check("rsp_seen", bus.rsp_valid_o, 1'b1);
      check("rsp_cycle", c, exp_cyc);
      check("rsp_dat", bus.rsp_dat_o, exp_dat);
      check("rsp_err", bus.rsp_err_o, exp_err);
      check("rsp_tmo", bus.rsp_tmo_o, exp_tmo);
      check("rsp_cyc_low", bus.wb_cyc_o, 1'b0);

      // Back-pressure with stray terminations on the idle bus.
      hold = (hold_in < 0) ? $urandom_range(0, 5) : hold_in;
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready_i = 1'b0;
         bus.wb_ack_i    = 1'($urandom_range(0, 1));
         bus.wb_err_i    = 1'($urandom_range(0, 1));
         bus.wb_rty_i    = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", bus.rsp_valid_o, 1'b1);
         check("hold_rsp", {bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_tmo_o}, {exp_dat, exp_err, exp_tmo});
         check("hold_quiet", {bus.wb_cyc_o, bus.wb_stb_o, bus.cmd_ready_o}, 3'b000);
      end
      slave_idle();
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      check("post_handshake", {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
   endtask

   initial begin
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = '0;
      bus.cmd_sel_i   = '0;
      bus.cmd_dat_i   = '0;
      bus.rsp_ready_i = 1'b0;
      slave_idle();
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         slv_mem[i] = ref_mem[i];
      end
      ref_mem[0] = 32'hCAFE_0001;
      slv_mem[0] = 32'hCAFE_0001;

      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_tmo_o,
             bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o},
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 4'h0});
      check("reset_wdat", bus.wb_dat_o, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // write cal_ctrl, ack one cycle after strobe, then read it back
      set_step(0, k_ack, 1, 1'b0);
      run_txn(1'b1, 14'h0003, 4'hF, 32'h0000_0002, -1, 0);
      set_step(0, k_ack, 0, 1'b0);
      run_txn(1'b0, 14'h0003, 4'hF, 32'h0, -1, 0);
      // stalled read, ack three cycles into the strobe
      set_step(0, k_ack, 3, 1'b1);
      run_txn(1'b0, 14'h0000, 4'hF, 32'h0, -1, -1);
      // RTY, RTY, ACK
      set_step(0, k_rty, 1, 1'b0);
      set_step(1, k_rty, 0, 1'b1);
      set_step(2, k_ack, 2, 1'b0);
      run_txn(1'b0, 14'h0005, 4'hF, 32'h0, -1, -1);
      // four RTYs exhaust the retry budget
      for (int i = 0; i < 4; i++) set_step(i, k_rty, 1, 1'b0);
      run_txn(1'b1, 14'h0006, 4'h3, 32'h1234_5678, -1, -1);
      // silent slave -> timeout, late terminations while holding
      set_step(0, k_none, 1000, 1'b0);
      run_txn(1'b0, 14'h0007, 4'hF, 32'h0, -1, 5);
      set_step(0, k_ack, 0, 1'b0);
      run_txn(1'b0, 14'h0003, 4'hF, 32'h0, -1, 0);
      // ERR together with ACK, held response
      set_step(0, k_errack, 2, 1'b0);
      run_txn(1'b0, 14'h0000, 4'hF, 32'h0, -1, 5);
      // reset while waiting for the ack, then a normal command
      set_step(0, k_ack, 8, 1'b0);
      run_txn(1'b0, 14'h0005, 4'hF, 32'h0, 3, 0);
      set_step(0, k_ack, 2, 1'b1);
      run_txn(1'b0, 14'h0000, 4'hF, 32'h0, -1, 0);

      for (int t = 0; t < 60; t++) begin
         gen_script();
         run_txn(1'($urandom_range(0, 1)), c_aw'($urandom_range(0, 15)),
                 4'($urandom_range(1, 15)), $urandom, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1, "watchdog");
   end

endmodule : tb_wb_cmd_master
`default_nettype wire

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-outstanding Wishbone pipelined master that turns a valid/ready command stream into bus transactions toward the CSR slave bus (registers, I2C submap, ADC RAMs). It sits between the host-side command source (UART/PCIe bridge, test sequencer) and the CSR decoder. It returns read data and status over a valid/ready response stream. It implements retry-on-RTY and a bus timeout so that a hung slave cannot lock the command path.

## Interface
- g_addr_width, 14, word-address width (byte address bits [g_addr_width+1:2])
- g_timeout, 255, cycles from first STB to give-up; range 2..65535
- g_max_retry, 3, reissues after RTY before reporting error; 0 = none

- clk_i  in  1  system clock
- rst_n_i  in  1  reset; one clock, reset is synchronous and active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1 = write
- cmd_adr_i  in  g_addr_width  word address
- cmd_sel_i  in  4  byte selects
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  32  read data (0 for writes/errors)
- rsp_err_o  out  1  ERR seen, or RTY after exhausting retries
- rsp_tmo_o  out  1  timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls
- wb_adr_o  out  g_addr_width  address
- wb_sel_o  out  4  selects
- wb_dat_o  out  32  write data
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1  slave status
- wb_dat_i  in  32  read data

## Operation
- FSM: IDLE, REQ, WAIT, RESP. All outputs registered.
- IDLE: cmd_ready_o=1. On accept, latch we/adr/sel/dat, clear retry count and timer, go to REQ.
- REQ: cyc=stb=1. If stall=0, the strobe is taken; go to WAIT. Termination (ack/err/rty) in REQ is also legal, because this slave holds stall high until ack; handle it exactly as in WAIT.
- WAIT: cyc=1, stb=0, until termination.
- Termination priority is err > rty > ack when more than one is high.
  - ack: capture wb_dat_i (reads only), go to RESP.
  - err: set rsp_err, go to RESP.
  - rty with retry count < g_max_retry: increment the count, reload the timer, drop cyc for exactly one cycle, then re-enter REQ.
  - rty otherwise: set rsp_err, go to RESP.
- Timeout: the timer counts every cycle in REQ/WAIT. When it reaches g_timeout-1 with no termination, drop cyc/stb, set rsp_tmo, go to RESP.
- RESP: rsp_valid_o=1, cyc=0. On rsp_ready_i, go to IDLE.
- rsp_dat_o, rsp_err_o and rsp_tmo_o hold stable while rsp_valid_o=1. rsp_err and rsp_tmo are never both set.
- A termination arriving while cyc=0 (late ack after timeout) is ignored.
- Reset values: every output 0 except cmd_ready_o=1. The FSM goes to IDLE and drops any transaction in flight, including mid-REQ/WAIT and mid-RESP, with no response emitted.

## Timing
- Accept at cycle 0 → cyc/stb high at cycle 1.
- Zero-stall slave acking in cycle 1 (in REQ) → rsp_valid_o at cycle 2.
- Slave with stall=1 until ack → same latency as its ack delay plus 1.
- cmd_ready_o is low from the cycle after accept until the cycle after rsp handshake. Minimum command-to-command spacing is 3 cycles.
- A retry costs 1 idle cycle (cyc=0) plus the new strobe.
- Timeout fires with rsp_valid_o exactly g_timeout+1 cycles after accept.
- wb_adr/sel/we/dat are stable from the first STB until cyc drops.

## Structure
- Shared package wb_cmd_master_pkg holds:
  - FSM state enum (IDLE/REQ/WAIT/RESP)
  - response record (dat, err, tmo)
  - c_wb_data_width=32 and c_wb_sel_width=4
- Sub-module wb_cmd_timeout: loadable down-counter with load/enable/expired; width = clog2(g_timeout+1).
- The rest stays in one module.

## Test plan
- Write 0x00000002 to word 0x0003 (cal_ctrl), slave acks 1 cycle after STB → WB shows we=1, sel=0xF. rsp_valid at cycle 3 with err=0, tmo=0. Readback returns 0x00000002.
- Read word 0x0000 against a slave with stall=1 until ack at cycle 4 (ident_i[63:32]=0xCAFE0001) → rsp_dat=0xCAFE0001; stb dropped only after stall low.
- Slave answers RTY twice then ACK, g_max_retry=3 → three strobes, exactly one idle cycle between them, final rsp err=0. With RTY four times → rsp err=1 after the 4th strobe.
- Slave never answers, g_timeout=16 → cyc drops, rsp_tmo=1 at cycle 17. An ack injected at cycle 20 is ignored. The next command completes normally.
- ERR and ACK asserted together → rsp_err=1, rsp_dat=0. Hold rsp_ready_i low for 5 cycles → outputs stable and no new STB.
- Assert rst_n_i low for 1 cycle during WAIT → next cycle cyc=stb=0, cmd_ready_o=1, rsp_valid_o=0. A following command completes normally.
